// File: rtl/weight_loader.sv
// weight_loader: sole initiator of the core_matrix weight write/read port.
// Takes (source, destination, weight) entries, checks the indices, writes the
// weight with a one-cycle strobe and, when verify is requested, reads it back
// and rewrites up to MAX_RETRY times before declaring the entry failed.
//
// Ports:
//   clk, axi_rst           clock, asynchronous active-high reset
//   in_valid/in_ready      entry handshake (in_ready is combinational)
//   in_s, in_d, in_data    source index, destination index, weight word
//   verify_en              read-back verify for this entry, sampled at accept
//   wready, wr_addr, wdata write strobe, address, data to core_matrix
//   rd_addr, rdata         read-back address (same register as wr_addr), data
//   busy                   loader not idle
//   wr_count, err_count    saturating good-entry / failed-entry counters
//   err, err_clr           sticky error flag and its clear (clears err_count too)

`ifndef WEIGHT_ADDR_MASK
`define WEIGHT_ADDR_MASK 8'h40
`endif

module weight_loader #(
    parameter int N         = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        axi_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_s,
    input  logic [10:0] in_d,
    input  logic [31:0] in_data,
    input  logic        verify_en,
    output logic        wready,
    output logic [31:0] wr_addr,
    output logic [31:0] wdata,
    output logic [31:0] rd_addr,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic [15:0] wr_count,
    output logic [15:0] err_count,
    output logic        err,
    input  logic        err_clr
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // WAIT lasts RD_LAT-1 cycles, so the down-counter starts at RD_LAT-2.
    localparam int WW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, WAIT, CHECK} state_t;

    state_t        state;
    logic [31:0]   addr_q;
    logic [RW-1:0] retry;
    logic [WW-1:0] wait_cnt;
    logic          verify_q;

    logic accept, entry_bad, mismatch, retry_left, err_ev, wr_ev;

    assign in_ready   = (state == IDLE) & ~axi_rst;
    assign accept     = in_valid & in_ready;
    // Diagonal cells are shorted in the array, so s==d is rejected too.
    assign entry_bad  = (in_s == in_d) || ({21'd0, in_s} >= 32'(N)) || ({21'd0, in_d} >= 32'(N));
    assign mismatch   = (rdata != wdata);
    assign retry_left = (retry < RW'(MAX_RETRY));
    assign err_ev     = (accept & entry_bad) | ((state == CHECK) & mismatch & ~retry_left);
    assign wr_ev      = ((state == WRITE) & ~verify_q) | ((state == CHECK) & ~mismatch);

    // Read and write share one address register; core_matrix only looks at
    // rd_addr while wready is low.
    assign wr_addr = addr_q;
    assign rd_addr = addr_q;

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata     <= '0;
            retry     <= '0;
            wait_cnt  <= '0;
            verify_q  <= 1'b0;
            wready    <= 1'b0;
            busy      <= 1'b0;
            wr_count  <= '0;
            err_count <= '0;
            err       <= 1'b0;
        end else begin
            wready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !entry_bad) begin
                        addr_q   <= {`WEIGHT_ADDR_MASK, in_d, in_s, 2'b00};
                        wdata    <= in_data;
                        verify_q <= verify_en;
                        retry    <= '0;
                        wready   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (!verify_q) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (RD_LAT == 1) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= WW'(RD_LAT - 2);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) state <= CHECK;
                    else                wait_cnt <= wait_cnt - WW'(1);
                end
                CHECK: begin
                    if (mismatch && retry_left) begin
                        retry  <= retry + RW'(1);
                        wready <= 1'b1;
                        state  <= WRITE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            if (wr_ev && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;

            // A new error in the same cycle as err_clr leaves a count of one.
            if (err_ev) begin
                err <= 1'b1;
                if (err_clr)                     err_count <= 16'd1;
                else if (err_count != 16'hFFFF)  err_count <= err_count + 16'd1;
            end else if (err_clr) begin
                err       <= 1'b0;
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: directed cases plus a random entry stream, checked
// every cycle against a timestamp model (pulse schedule, free time, counter
// update times derived from the entry's verify flag and flaky-write count).

`ifndef WEIGHT_ADDR_MASK
`define WEIGHT_ADDR_MASK 8'h40
`endif

module tb_weight_loader;
    localparam int N = 8, RD_LAT = 2, MAX_RETRY = 2, P = 1 + RD_LAT;

    logic        clk = 1'b0;
    logic        axi_rst = 1'b1;
    logic        in_valid = 1'b0, verify_en = 1'b0, err_clr = 1'b0;
    logic [10:0] in_s = '0, in_d = '0;
    logic [31:0] in_data = '0;
    logic        in_ready, wready, busy, err;
    logic [31:0] wr_addr, wdata, rd_addr, rdata;
    logic [15:0] wr_count, err_count;

    weight_loader #(.N(N), .RD_LAT(RD_LAT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .axi_rst(axi_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_d(in_d), .in_data(in_data), .verify_en(verify_en),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata), .rd_addr(rd_addr),
        .rdata(rdata), .busy(busy), .wr_count(wr_count), .err_count(err_count),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- core_matrix stand-in ----------------
    // The first acc_k writes of an accepted entry store the inverted word,
    // modelling a flaky cell; stuck0 forces every read to zero.
    logic [31:0] mem [64];
    int   wr_seen = 0;
    int   acc_base = 0, acc_k = 0, ent_k = 0;
    logic stuck0 = 1'b0;

    function automatic int idx(input logic [31:0] a);
        return int'({a[15:13], a[4:2]});
    endfunction

    assign rdata = stuck0 ? 32'd0 : mem[idx(rd_addr)];

    always @(posedge clk) begin
        if (wready) begin
            mem[idx(wr_addr)] <= (wr_seen - acc_base < acc_k) ? ~wdata : wdata;
            wr_seen <= wr_seen + 1;
        end
    end

    // ---------------- checking ----------------
    int vec = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model state: current entry's pulse schedule and free time, plus the
    // cycles at which counter/flag updates become visible.
    int          m_free = 0, m_p0 = 0, m_att = 0, keff, ms, md;
    int          at_clr = -1, at_err = -1, at_wr = -1;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [15:0] m_wrc = '0, m_errc = '0;
    logic        m_err = 1'b0, exp_busy, exp_wr;

    // Literal pins requested by the stimulus, checked here.
    int          pin_seq = 0, pin_done = 0, pin_base = 0, pin_wrc, pin_errc, pin_pulses;
    logic        pin_err, pin_aen;
    logic [31:0] pin_addr;

    always @(negedge clk) begin
        if (axi_rst) begin
            m_free = 0; m_att = 0; m_addr = '0; m_data = '0;
            m_wrc = '0; m_errc = '0; m_err = 1'b0;
            at_clr = -1; at_err = -1; at_wr = -1;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_wready", 32'(wready), 32'd0);
            chk("rst_wr_addr", wr_addr, 32'd0);
            chk("rst_rd_addr", rd_addr, 32'd0);
            chk("rst_wdata", wdata, 32'd0);
            chk("rst_wr_count", 32'(wr_count), 32'd0);
            chk("rst_err_count", 32'(err_count), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
        end else begin
            if (at_clr == cyc) begin m_err = 1'b0; m_errc = '0; end
            if (at_err == cyc) begin
                m_err = 1'b1;
                if (m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
            end
            if (at_wr == cyc && m_wrc != 16'hFFFF) m_wrc = m_wrc + 16'd1;

            exp_busy = (cyc < m_free);
            exp_wr = (m_att > 0) && (cyc >= m_p0) && ((cyc - m_p0) % P == 0)
                     && ((cyc - m_p0) / P < m_att);

            chk("in_ready", 32'(in_ready), 32'(!exp_busy));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("wready", 32'(wready), 32'(exp_wr));
            chk("wr_addr", wr_addr, m_addr);
            chk("rd_addr", rd_addr, m_addr);
            chk("wdata", wdata, m_data);
            chk("wr_count", 32'(wr_count), 32'(m_wrc));
            chk("err_count", 32'(err_count), 32'(m_errc));
            chk("err", 32'(err), 32'(m_err));

            if (in_valid && !exp_busy) begin
                ms = int'(in_s);
                md = int'(in_d);
                if (ms == md || ms >= N || md >= N) begin
                    at_err = cyc + 1;
                end else begin
                    m_addr = {`WEIGHT_ADDR_MASK, in_d, in_s, 2'b00};
                    m_data = in_data;
                    m_p0   = cyc + 1;
                    if (!verify_en) begin
                        m_att  = 1;
                        m_free = cyc + 2;
                        at_wr  = cyc + 2;
                    end else begin
                        keff   = stuck0 ? 1000 : ent_k;
                        m_att  = ((keff < MAX_RETRY) ? keff : MAX_RETRY) + 1;
                        m_free = cyc + 1 + m_att * P;
                        if (keff <= MAX_RETRY) at_wr = m_free;
                        else                   at_err = m_free;
                    end
                end
            end
            if (err_clr) at_clr = cyc + 1;
        end

        if (pin_seq != pin_done) begin
            pin_done = pin_seq;
            chk("pin_wr_count", 32'(wr_count), 32'(pin_wrc));
            chk("pin_err_count", 32'(err_count), 32'(pin_errc));
            chk("pin_err", 32'(err), 32'(pin_err));
            chk("pin_pulses", 32'(wr_seen - pin_base), 32'(pin_pulses));
            if (pin_aen) chk("pin_wr_addr", wr_addr, pin_addr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int s, input int d, input logic [31:0] data,
                        input logic v, input int k, input logic clr);
        bit ok = 0;
        in_valid = 1'b1; in_s = 11'(s); in_d = 11'(d); in_data = data;
        verify_en = v; ent_k = k; err_clr = clr;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                acc_base = wr_seen;
                acc_k = k;
            end
        end
        if (!ok) begin
            $display("FAIL accept_timeout at cycle %0d: in_ready never rose", cyc);
            $fatal(1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy && in_ready) ok = 1;
        end
        if (!ok) begin
            $display("FAIL idle_timeout at cycle %0d: busy stuck high", cyc);
            $fatal(1);
        end
        @(posedge clk); #1;
    endtask

    task automatic pin(input int wrc, input int errc, input logic e, input int pulses,
                       input logic aen, input logic [31:0] a);
        pin_wrc = wrc; pin_errc = errc; pin_err = e; pin_pulses = pulses;
        pin_aen = aen; pin_addr = a;
        pin_seq++;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int s, d;
        idle(3);
        axi_rst = 1'b0;
        idle(1);

        // Plain write, no verify.
        pin_base = wr_seen;
        send(1, 3, 32'h5, 1'b0, 0, 1'b0);
        wait_idle();
        pin(1, 0, 1'b0, 1, 1'b1, 32'h4000_6004);

        // Verify, read-back matches first time.
        pin_base = wr_seen;
        send(2, 5, 32'hCAFE_0001, 1'b1, 0, 1'b0);
        wait_idle();
        pin(2, 0, 1'b0, 1, 1'b1, 32'h4000_A008);

        // Verify against a stuck-at-zero cell: three writes, then failure.
        axi_rst = 1'b1; idle(2); axi_rst = 1'b0; idle(1);
        stuck0 = 1'b1;
        pin_base = wr_seen;
        send(0, 1, 32'h7, 1'b1, 0, 1'b0);
        wait_idle();
        pin(0, 1, 1'b1, 3, 1'b0, 32'h0);
        stuck0 = 1'b0;

        // Invalid entries: diagonal, then out-of-range source.
        pin_base = wr_seen;
        send(4, 4, 32'h1, 1'b0, 0, 1'b0);
        send(8, 0, 32'h2, 1'b0, 0, 1'b0);
        wait_idle();
        pin(0, 3, 1'b1, 0, 1'b0, 32'h0);

        // err_clr alone, then coincident with an invalid entry.
        err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(1);
        pin(0, 0, 1'b0, 0, 1'b0, 32'h0);
        send(3, 3, 32'h9, 1'b0, 0, 1'b1);
        wait_idle();
        pin(0, 1, 1'b1, 0, 1'b0, 32'h0);

        // Sixteen back-to-back entries with in_valid held high.
        pin_base = wr_seen;
        for (int i = 0; i < 16; i++)
            send(i % 8, (i + 1) % 8, 32'h100 + 32'(i), 1'b0, 0, 1'b0);
        wait_idle();
        pin(16, 1, 1'b1, 16, 1'b1, 32'h4000_001C);

        // Reset while waiting for read-back, then a clean entry.
        send(1, 2, 32'hA5A5_0000, 1'b1, 0, 1'b0);
        @(posedge clk); #1;
        axi_rst = 1'b1;
        idle(2);
        axi_rst = 1'b0;
        idle(1);
        pin_base = wr_seen;
        pin(0, 0, 1'b0, 0, 1'b1, 32'h0);
        send(6, 1, 32'h21, 1'b1, 0, 1'b0);
        wait_idle();
        pin(1, 0, 1'b0, 1, 1'b1, 32'h4000_2018);

        // Random stream: mixed validity, verify, flaky writes and clears.
        for (int i = 0; i < 80; i++) begin
            s = $urandom_range(0, 9);
            d = $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0) s = 2047;
            send(s, d, $urandom | 32'h1, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 1) == 1) wait_idle();
            idle($urandom_range(0, 2));
        end
        wait_idle();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Bus initiator that programs and verifies coupling weights in the `core_matrix` weight register space. It accepts a stream of (source index, destination index, weight) entries and issues single-cycle writes on the `wready`/`wr_addr`/`wdata` port. When verification is enabled, it reads each weight back on `rd_addr`/`rdata`, compares it, and retries on mismatch. It sits between the host-side command path and `core_matrix`, and is the only master of that port.

## Interface
Parameters:
- `N`, 8: oscillator count. Valid indices are 0..N-1.
- `RD_LAT`, 1: cycles from `rd_addr` valid to `rdata` sampled. Must be ≥1.
- `MAX_RETRY`, 2: rewrite attempts after a verify mismatch before the entry is declared failed.

Ports:
- `clk`, in, 1: single clock.
- `axi_rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: entry valid.
- `in_ready`, out, 1: loader can accept an entry.
- `in_s`, in, 11: source index.
- `in_d`, in, 11: destination index.
- `in_data`, in, 32: weight word.
- `verify_en`, in, 1: read-back verify; sampled at accept.
- `wready`, out, 1: write strobe to `core_matrix`.
- `wr_addr`, out, 32: write address.
- `wdata`, out, 32: write data.
- `rd_addr`, out, 32: read address.
- `rdata`, in, 32: read data from `core_matrix`.
- `busy`, out, 1: high in any state other than IDLE.
- `wr_count`, out, 16: entries successfully written (verified, if verify was on).
- `err_count`, out, 16: rejected or failed entries.
- `err`, out, 1: sticky error flag.
- `err_clr`, in, 1: clears `err` and `err_count`.

## Operation
- Address encoding: `wr_addr = {WEIGHT_ADDR_MASK, d[10:0], s[10:0], 2'b00}`, where `WEIGHT_ADDR_MASK` is the `WEIGHT_ADDR_MASK` define.
  - `rd_addr` is driven from the same register as `wr_addr`, so the two are always equal.
  - `core_matrix` uses `rd_addr` only while `wready` is 0.
- FSM states are IDLE, WRITE, WAIT, CHECK.
- IDLE:
  - `in_ready = (state==IDLE) & ~axi_rst`.
  - On `in_valid & in_ready`, the entry is validated.
  - Invalid means `s==d` (diagonal / shorted cell), `s>=N`, or `d>=N`.
  - An invalid entry is consumed. No write is issued, `err_count` increments, `err` is set, and the FSM stays in IDLE.
  - A valid entry is captured into the address/data registers, retry counter=0, verify flag=`verify_en`, and the FSM goes to WRITE.
- WRITE:
  - `wready=1` for exactly one cycle.
  - If the verify flag is 0: `wr_count` increments and the FSM goes to IDLE.
  - Otherwise the FSM goes to WAIT.
- WAIT:
  - `wready=0` and `rd_addr` is held.
  - A counter runs for RD_LAT-1 cycles; when RD_LAT=1 the FSM goes directly to CHECK.
- CHECK:
  - `rdata` is compared with the held `wdata`, all 32 bits.
  - Match: `wr_count` increments and the FSM goes to IDLE.
  - Mismatch with retries<MAX_RETRY: retries increment and the FSM goes to WRITE.
  - Mismatch with retries==MAX_RETRY: `err_count` increments, `err` is set, and the FSM goes to IDLE.
- Counters saturate at 16'hFFFF.
- If `err_clr` and a new error occur in the same cycle, the error wins: `err`=1 and `err_count`=1.
- `wr_addr`, `wdata` and `rd_addr` hold their last values while `wready`=0.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready` 0 while `axi_rst` is high, 1 after release.
  - `wready` 0.
  - `wr_addr`/`rd_addr`/`wdata` 0.
  - `wr_count`/`err_count` 0.
  - `err` 0.
  - `busy` 0.
- With an accept at cycle T:
  - `wready`=1 in cycle T+1 with registered address and data.
  - Without verify: `in_ready` rises again at T+2, so peak throughput is 1 entry per 2 cycles.
  - With verify: CHECK samples `rdata` at cycle T+1+RD_LAT, and a passing entry frees the loader at T+2+RD_LAT.
- Each retry adds 1+RD_LAT cycles.
- All outputs are registered except `in_ready`.
- `axi_rst` asserted mid-operation aborts immediately to reset values. No partial write strobe is produced afterwards.

## Test plan
- Valid write, verify off: s=1, d=3, data=32'h5 → one `wready` pulse at T+1, `wr_addr`={MASK,11'd3,11'd1,2'b00}, `wr_count`=1, `in_ready` high at T+2.
- Verify pass, RD_LAT=2: `rdata` model returns the written data → no second `wready`, `wr_count`=1, `busy` low at T+4.
- Verify fail: `rdata` model stuck at 0, data=32'h7, MAX_RETRY=2 → 3 `wready` pulses total, then `err`=1, `err_count`=1, `wr_count`=0.
- Invalid entries: s=d=4, then s=8 with N=8 → no `wready`, `err_count`=2, `in_ready` stays high throughout.
- Back-to-back stream of 16 valid entries with `in_valid` held high, verify off → 16 pulses at 2-cycle spacing, `wr_count`=16.
- Reset during WAIT: `axi_rst` pulsed → all outputs at reset values asynchronously and the next accept starts clean; `err_clr` coincident with an invalid entry → `err`=1, `err_count`=1.
